// File: rtl/neuron_mac.sv
// -----------------------------------------------------------------------------
// neuron_mac
//
// Sequential multiply-accumulate stage for one neuron's pre-activation value.
// It sums N_INPUTS signed Q8.8 input x weight products (each a Q16.16
// product) into a Q24.16 accumulator, adds a Q8.8 bias, and returns the
// result as a Q8.8 word. The result is truncated toward minus infinity.
// This stage feeds the 16-bit input of the sigmoid activation stage.
//
// Parameters
//   N_INPUTS   products accumulated per neuron (1..256)
//   ACC_W      accumulator width in bits (Q24.16, 40 by default)
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   start      begin a new neuron; sampled only while idle
//   bias       signed Q8.8 bias, latched when start is accepted
//   in_valid   in_data/in_weight valid
//   in_ready   stage accepts a pair this cycle
//   in_data    signed Q8.8 activation
//   in_weight  signed Q8.8 weight
//   out_valid  out_sum valid
//   out_ready  downstream accepts out_sum
//   out_sum    signed Q8.8 pre-activation result
//   busy       high whenever the stage is not idle
//
// Configuration
//   NEURON_MAC_SAT_EN  when defined, the result saturates to 16'h7FFF and
//                      16'h8000. When undefined, the result wraps in two's
//                      complement and no saturation comparators are built.
// -----------------------------------------------------------------------------
module neuron_mac #(
  parameter int N_INPUTS = 16,
  parameter int ACC_W    = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] bias,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic [15:0] in_weight,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_sum,
  output logic        busy
);

  // The counter must be able to reach N_INPUTS, which is 256 at most.
  localparam int CNT_W = $clog2(N_INPUTS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_INPUTS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    FINAL,
    OUT
  } state_t;

  state_t                   r_state;
  state_t                   w_nextState;
  logic signed [ACC_W-1:0]  r_acc;
  logic        [CNT_W-1:0]  r_beatCnt;
  logic        [15:0]       r_bias;
  logic        [15:0]       r_outSum;

  logic signed [31:0]       w_dataExt;
  logic signed [31:0]       w_weightExt;
  logic signed [31:0]       w_prod;
  logic signed [ACC_W-1:0]  w_prodExt;
  logic                     w_beat;
  logic        [15:0]       w_result;

  // Both operands are widened to 32 bits before multiplying. The low 32 bits
  // of that product equal the exact 16x16 signed product.
  assign w_dataExt   = {{16{in_data[15]}}, in_data};
  assign w_weightExt = {{16{in_weight[15]}}, in_weight};
  assign w_prod      = w_dataExt * w_weightExt;
  assign w_prodExt   = {{(ACC_W-32){w_prod[31]}}, w_prod};

  // A beat is accepted only while accumulating. in_ready is high in exactly
  // that state.
  assign w_beat = in_valid && (r_state == ACCUM);

`ifdef NEURON_MAC_SAT_EN
  // (acc + bias<<8) >>> 8 equals (acc >>> 8) + bias, because bias<<8 has
  // zero fraction bits. The full-width sum is kept so overflow can be detected.
  localparam logic signed [ACC_W-9:0] R_MAX = (ACC_W-8)'(32767);
  localparam logic signed [ACC_W-9:0] R_MIN = (ACC_W-8)'(-32768);

  logic signed [ACC_W-9:0] w_rFull;

  assign w_rFull = $signed(r_acc[ACC_W-1:8])
                 + $signed({{(ACC_W-24){r_bias[15]}}, r_bias});

  // Clamp the shifted sum to the Q8.8 range.
  always_comb begin
    w_result = w_rFull[15:0];
    if (w_rFull > R_MAX) begin
      w_result = 16'h7FFF;
    end else if (w_rFull < R_MIN) begin
      w_result = 16'h8000;
    end
  end
`else
  // With wrap-around, only the low 16 bits of (acc >>> 8) + bias matter.
  assign w_result = r_acc[23:8] + r_bias;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. A start seen outside IDLE is dropped, including one
  // that arrives together with the output handshake.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start) w_nextState = ACCUM;
      ACCUM:   if (w_beat && (r_beatCnt == LAST_CNT)) w_nextState = FINAL;
      FINAL:   w_nextState = OUT;
      OUT:     if (out_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Datapath registers.
  // The accumulator and beat counter change only on an accepted beat, so a
  // stall holds them. out_sum is loaded once per neuron, in FINAL, and then
  // stays stable while the result is offered downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc     <= '0;
      r_beatCnt <= '0;
      r_bias    <= '0;
      r_outSum  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_bias    <= bias;
            r_acc     <= '0;
            r_beatCnt <= '0;
          end
        end
        ACCUM: begin
          if (w_beat) begin
            r_acc     <= r_acc + w_prodExt;
            r_beatCnt <= r_beatCnt + CNT_W'(1);
          end
        end
        FINAL: begin
          r_outSum <= w_result;
        end
        default: begin
        end
      endcase
    end
  end

  // All handshake outputs are decoded from the state register. No input
  // reaches an output combinationally.
  assign in_ready  = (r_state == ACCUM);
  assign out_valid = (r_state == OUT);
  assign busy      = (r_state != IDLE);
  assign out_sum   = r_outSum;

endmodule
